// File: rtl/pierogi_pkg.sv
// Shared defaults for the register file / scoreboard slice.
package pierogi_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;
    localparam int REG_ZERO   = 0;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: hardwired-zero, write bypass and busy masking.
module regfile_read_port
    import pierogi_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] reg_data_i,
    input  logic              busy_i,
    input  logic              wr_ok_i,
    input  logic              wr_clr_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o
);
    logic is_zero, hit;

    assign is_zero = (ZERO_REG != 0) && (addr_i == ADDR_W'(REG_ZERO));
    assign hit     = (BYPASS != 0) && wr_ok_i && (wr_addr_i == addr_i);

    always_comb begin
        data_o = reg_data_i;
        busy_o = busy_i;
        if (hit) begin
            data_o = wr_data_i;
            // the write retiring this register's producer also clears its busy bit
            if (wr_clr_i) busy_o = 1'b0;
        end
        if (is_zero || rst_i) begin
            data_o = '0;
            busy_o = 1'b0;
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two read ports, one write port and a per-register busy scoreboard.
module regfile_scoreboard
    import pierogi_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_busy,
    output logic [ADDR_W:0]   pending_cnt
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    logic wr_ok, wr_clr, accept, iss_zero;
    logic [1:0][ADDR_W-1:0] rp_addr;
    logic [1:0][DATA_W-1:0] rp_data;
    logic [1:0]             rp_busy;

    assign wr_ok    = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO)));
    assign wr_clr   = wr_en && busy_q[wr_addr];
    assign iss_zero = (ZERO_REG != 0) && (issue_addr == ADDR_W'(REG_ZERO));

    always_comb begin
        issue_busy = busy_q[issue_addr];
        if ((BYPASS != 0) && wr_clr && (wr_addr == issue_addr)) issue_busy = 1'b0;
        if (rst) issue_busy = 1'b0;
    end

    assign accept = issue_en && !issue_busy && !iss_zero;

    // clear first, then set: a new producer issuing on the retiring register wins
    always_comb begin
        busy_d = busy_q;
        if (wr_clr) busy_d[wr_addr] = 1'b0;
        if (accept) busy_d[issue_addr] = 1'b1;
        cnt_d = cnt_q + (ADDR_W+1)'(accept) - (ADDR_W+1)'(wr_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) regs_q[wr_addr] <= wr_data;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_cnt = cnt_q;
    assign rp_addr[0]  = rd_addr_a;
    assign rp_addr[1]  = rd_addr_b;

    for (genvar p = 0; p < 2; p++) begin : g_rp
        regfile_read_port #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rp (
            .rst_i      (rst),
            .addr_i     (rp_addr[p]),
            .reg_data_i (regs_q[rp_addr[p]]),
            .busy_i     (busy_q[rp_addr[p]]),
            .wr_ok_i    (wr_ok),
            .wr_clr_i   (wr_clr),
            .wr_addr_i  (wr_addr),
            .wr_data_i  (wr_data),
            .data_o     (rp_data[p]),
            .busy_o     (rp_busy[p])
        );
    end

    assign rd_data_a = rp_data[0];
    assign rd_data_b = rp_data[1];
    assign busy_a    = rp_busy[0];
    assign busy_b    = rp_busy[1];
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: default DUT plus a BYPASS=0 copy sharing the same stimulus.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rd_addr_a, rd_addr_b, wr_addr, issue_addr;
    logic [31:0] wr_data;
    logic        wr_en, issue_en;

    logic [31:0] rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b;
    logic        busy_a, busy_b, issue_busy, nb_busy_a, nb_busy_b, nb_issue_busy;
    logic [4:0]  pending_cnt, nb_pending_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .busy_a(busy_a), .busy_b(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .issue_busy(issue_busy),
        .pending_cnt(pending_cnt)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(nb_rd_data_a), .rd_data_b(nb_rd_data_b), .busy_a(nb_busy_a),
        .busy_b(nb_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .issue_busy(nb_issue_busy),
        .pending_cnt(nb_pending_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one edge; inputs change 1ns after the edge, checks 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; issue_en = 0;
        rd_addr_a = 0; rd_addr_b = 0; wr_addr = 0; issue_addr = 0; wr_data = 0;
        #2;
        chk("rst_rd_a", rd_data_a, 32'h0);
        chk("rst_cnt", {27'b0, pending_cnt}, 32'd0);
        step();
        rst = 1'b0;

        // write then read back; same-cycle bypass vs no bypass
        wr_en = 1; wr_addr = 5; wr_data = 32'hA5A5A5A5;
        step();
        wr_en = 0; rd_addr_a = 5; #1;
        chk("rd_r5", rd_data_a, 32'hA5A5A5A5);
        wr_en = 1; wr_addr = 10; wr_data = 32'h5A5A5A5A; rd_addr_b = 10; #1;
        chk("bypass_b", rd_data_b, 32'h5A5A5A5A);
        chk("nobypass_b", nb_rd_data_b, 32'h0);
        step();
        wr_en = 0; #1;
        chk("nobypass_b_after", nb_rd_data_b, 32'h5A5A5A5A);

        // r0 hardwired
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; rd_addr_a = 0; #1;
        chk("r0_bypass_drop", rd_data_a, 32'h0);
        step();
        wr_en = 0; issue_en = 1; issue_addr = 0; #1;
        chk("r0_read", rd_data_a, 32'h0);
        step();
        issue_en = 0; #1;
        chk("r0_busy", {31'b0, busy_a}, 32'd0);
        chk("r0_cnt", {27'b0, pending_cnt}, 32'd0);

        // issue / re-issue / retire r3
        issue_en = 1; issue_addr = 3; #1;
        chk("iss3_free", {31'b0, issue_busy}, 32'd0);
        step();
        issue_en = 0; rd_addr_a = 3; #1;
        chk("busy3", {31'b0, busy_a}, 32'd1);
        chk("cnt_1", {27'b0, pending_cnt}, 32'd1);
        issue_en = 1; #1;
        chk("iss3_waw", {31'b0, issue_busy}, 32'd1);
        step();
        issue_en = 0; #1;
        chk("cnt_still_1", {27'b0, pending_cnt}, 32'd1);
        wr_en = 1; wr_addr = 3; wr_data = 32'h12345678; #1;
        chk("busy3_masked", {31'b0, busy_a}, 32'd0);
        chk("nb_busy3_unmasked", {31'b0, nb_busy_a}, 32'd1);
        step();
        wr_en = 0; #1;
        chk("busy3_clr", {31'b0, busy_a}, 32'd0);
        chk("cnt_0", {27'b0, pending_cnt}, 32'd0);
        chk("rd_r3", rd_data_a, 32'h12345678);

        // simultaneous retire + reissue of r7
        issue_en = 1; issue_addr = 7;
        step();
        rd_addr_a = 7; wr_en = 1; wr_addr = 7; wr_data = 32'hDEADBEEF; #1;
        chk("iss7_masked", {31'b0, issue_busy}, 32'd0);
        chk("rd7_bypass", rd_data_a, 32'hDEADBEEF);
        step();
        issue_en = 0; wr_en = 0; #1;
        chk("busy7_kept", {31'b0, busy_a}, 32'd1);
        chk("cnt7", {27'b0, pending_cnt}, 32'd1);
        chk("nb_cnt7", {27'b0, nb_pending_cnt}, 32'd0);
        chk("rd7", rd_data_a, 32'hDEADBEEF);
        wr_en = 1; wr_addr = 7;
        step();
        wr_en = 0; #1;
        chk("cnt7_clr", {27'b0, pending_cnt}, 32'd0);

        // fill and drain the scoreboard
        issue_en = 1;
        for (int i = 1; i < 16; i++) begin
            issue_addr = 4'(i);
            step();
        end
        issue_en = 0; rd_addr_b = 15; #1;
        chk("cnt_full", {27'b0, pending_cnt}, 32'd15);
        chk("busy15", {31'b0, busy_b}, 32'd1);
        wr_en = 1;
        for (int i = 1; i < 16; i++) begin
            wr_addr = 4'(i); wr_data = 32'h11111111 * i;
            step();
        end
        wr_en = 0; rd_addr_a = 9; #1;
        chk("cnt_drain", {27'b0, pending_cnt}, 32'd0);
        chk("rd_r9", rd_data_a, 32'h99999999);

        // reset mid-operation
        issue_en = 1; issue_addr = 4;
        step();
        issue_addr = 6;
        step();
        issue_en = 0; rd_addr_a = 4; #1;
        chk("pre_rst_cnt", {27'b0, pending_cnt}, 32'd2);
        rst = 1; wr_en = 1; wr_addr = 4; wr_data = 32'h11112222; issue_en = 1; #1;
        chk("midrst_rd", rd_data_a, 32'h0);
        chk("midrst_busy", {31'b0, busy_a}, 32'd0);
        chk("midrst_cnt", {27'b0, pending_cnt}, 32'd0);
        step();
        wr_en = 0; issue_en = 0; rst = 0; rd_addr_b = 5; #1;
        chk("postrst_r4", rd_data_a, 32'h0);
        chk("postrst_r5", rd_data_b, 32'h0);
        chk("postrst_cnt", {27'b0, pending_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
